// File: rtl/serial_frame_rx.sv
// serial_frame_rx: frames a serial bit stream into DATA_WIDTH-bit words.
// Each frame is a start bit (1), the payload LSB first, an even-parity bit
// and a stop bit (0). Good words are offered on a valid/ready port. Sticky
// error flags and a good-frame counter are kept for the control block.
//
// state  | meaning
// IDLE   | line idle, waiting for a start bit (1)
// DATA   | capturing payload bits, LSB first
// PARITY | folding the parity bit into the accumulator
// STOP   | checking the stop bit and deciding the frame outcome
module serial_frame_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  DATA_IN,
    output logic [DATA_WIDTH-1:0] WORD_OUT,
    output logic                  WORD_VALID,
    input  logic                  WORD_READY,
    output logic                  BUSY,
    output logic                  PARITY_ERR,
    output logic                  FRAME_ERR,
    output logic                  OVERRUN_ERR,
    input  logic                  ERR_CLEAR,
    output logic [CNT_WIDTH-1:0]  FRAME_COUNT
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [BW-1:0]           bit_cnt;
    logic                    parity_acc;

    // Frame FSM, output handshake, sticky errors and good-frame counter.
    // BUSY is registered alongside the state so it mirrors "state != IDLE".
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            parity_acc  <= 1'b0;
            WORD_OUT    <= '0;
            WORD_VALID  <= 1'b0;
            BUSY        <= 1'b0;
            PARITY_ERR  <= 1'b0;
            FRAME_ERR   <= 1'b0;
            OVERRUN_ERR <= 1'b0;
            FRAME_COUNT <= '0;
        end else begin
            // Consumer accept; a good frame completing on this edge overrides below.
            if (WORD_VALID && WORD_READY) begin
                WORD_VALID <= 1'b0;
            end

            // Clear first so that a set on the same edge wins.
            if (ERR_CLEAR) begin
                PARITY_ERR  <= 1'b0;
                FRAME_ERR   <= 1'b0;
                OVERRUN_ERR <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (DATA_IN) begin
                        state      <= DATA;
                        bit_cnt    <= '0;
                        parity_acc <= 1'b0;
                        BUSY       <= 1'b1;
                    end
                end
                DATA: begin
                    shift_reg[bit_cnt] <= DATA_IN;
                    parity_acc         <= parity_acc ^ DATA_IN;
                    bit_cnt            <= bit_cnt + BW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state <= PARITY;
                    end
                end
                PARITY: begin
                    parity_acc <= parity_acc ^ DATA_IN;
                    state      <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                    // A bad stop bit masks any parity verdict.
                    if (DATA_IN) begin
                        FRAME_ERR <= 1'b1;
                    end else if (parity_acc) begin
                        PARITY_ERR <= 1'b1;
                    end else if (!WORD_VALID || WORD_READY) begin
                        WORD_OUT    <= shift_reg;
                        WORD_VALID  <= 1'b1;
                        FRAME_COUNT <= FRAME_COUNT + CNT_WIDTH'(1);
                    end else begin
                        OVERRUN_ERR <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed vectors for serial_frame_rx (DATA_WIDTH=8,
// CNT_WIDTH=8) with hand-computed expected values.
module tb_serial_frame_rx;

    logic       CLK = 1'b0;
    logic       RESETn = 1'b0;
    logic       DATA_IN = 1'b0;
    logic [7:0] WORD_OUT;
    logic       WORD_VALID;
    logic       WORD_READY = 1'b0;
    logic       BUSY;
    logic       PARITY_ERR;
    logic       FRAME_ERR;
    logic       OVERRUN_ERR;
    logic       ERR_CLEAR = 1'b0;
    logic [7:0] FRAME_COUNT;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic pre_valid;

    serial_frame_rx #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .CLK        (CLK),
        .RESETn     (RESETn),
        .DATA_IN    (DATA_IN),
        .WORD_OUT   (WORD_OUT),
        .WORD_VALID (WORD_VALID),
        .WORD_READY (WORD_READY),
        .BUSY       (BUSY),
        .PARITY_ERR (PARITY_ERR),
        .FRAME_ERR  (FRAME_ERR),
        .OVERRUN_ERR(OVERRUN_ERR),
        .ERR_CLEAR  (ERR_CLEAR),
        .FRAME_COUNT(FRAME_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Start bit, 8 payload bits LSB first, parity bit, stop bit. WORD_READY
    // is driven to rdy_stop for the stop edge and left there afterwards.
    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stp, input logic rdy_stop);
        DATA_IN = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            DATA_IN = d[i];
            tick();
        end
        DATA_IN = par;
        tick();
        pre_valid  = WORD_VALID;
        WORD_READY = rdy_stop;
        DATA_IN    = stp;
        tick();
        DATA_IN = 1'b0;
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        tick();
        tick();
        RESETn = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        chk("rst_valid", WORD_VALID, 0);
        chk("rst_out", WORD_OUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_count", FRAME_COUNT, 0);
        chk("rst_errs", {PARITY_ERR, FRAME_ERR, OVERRUN_ERR}, 0);

        // Good frame 0xA5, parity 0
        WORD_READY = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        chk("a5_pre_valid", pre_valid, 0);
        chk("a5_valid", WORD_VALID, 1);
        chk("a5_out", WORD_OUT, 32'hA5);
        chk("a5_count", FRAME_COUNT, 1);
        chk("a5_errs", {PARITY_ERR, FRAME_ERR, OVERRUN_ERR}, 0);
        chk("a5_busy", BUSY, 0);
        tick();
        chk("a5_pulse_end", WORD_VALID, 0);

        // Parity error: 0x01 with parity 0
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        chk("par_err", PARITY_ERR, 1);
        chk("par_frame", FRAME_ERR, 0);
        chk("par_valid", WORD_VALID, 0);
        chk("par_count", FRAME_COUNT, 1);
        // Frame error: correct parity, stop bit 1
        send_frame(8'h01, 1'b1, 1'b1, 1'b1);
        chk("frm_err", FRAME_ERR, 1);
        chk("frm_par", PARITY_ERR, 1);
        chk("frm_count", FRAME_COUNT, 1);
        tick();
        chk("frm_stop_not_start", BUSY, 0);
        ERR_CLEAR = 1'b1;
        tick();
        ERR_CLEAR = 1'b0;
        chk("clr_errs", {PARITY_ERR, FRAME_ERR}, 0);
        // Bad parity and bad stop: frame error wins
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        chk("prio_frame", FRAME_ERR, 1);
        chk("prio_par", PARITY_ERR, 0);
        // Clear held through a parity-bad frame: the set wins on its edge
        ERR_CLEAR = 1'b1;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        chk("setwin_par", PARITY_ERR, 1);
        chk("setwin_frame", FRAME_ERR, 0);
        tick();
        ERR_CLEAR = 1'b0;
        chk("setwin_clr", PARITY_ERR, 0);

        // Overrun: 0x11 then 0x22 back-to-back with WORD_READY low
        do_reset();
        WORD_READY = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        chk("ovr_first_out", WORD_OUT, 32'h11);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0);
        chk("ovr_held_out", WORD_OUT, 32'h11);
        chk("ovr_valid", WORD_VALID, 1);
        chk("ovr_err", OVERRUN_ERR, 1);
        chk("ovr_count", FRAME_COUNT, 1);
        WORD_READY = 1'b1;
        tick();
        chk("ovr_drain", WORD_VALID, 0);
        WORD_READY = 1'b0;

        // Simultaneous accept and load on the completion edge of 0x22
        do_reset();
        send_frame(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        chk("sim_pre_valid", pre_valid, 1);
        chk("sim_out", WORD_OUT, 32'h22);
        chk("sim_valid", WORD_VALID, 1);
        chk("sim_count", FRAME_COUNT, 2);
        chk("sim_ovr", OVERRUN_ERR, 0);
        tick();
        chk("sim_drain", WORD_VALID, 0);

        // Reset after 4 payload bits
        DATA_IN = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            DATA_IN = 1'b1;
            tick();
        end
        chk("mid_busy", BUSY, 1);
        RESETn = 1'b0;
        #1;
        chk("mid_out", WORD_OUT, 0);
        chk("mid_count", FRAME_COUNT, 0);
        chk("mid_flags", {BUSY, WORD_VALID, PARITY_ERR, FRAME_ERR, OVERRUN_ERR}, 0);
        DATA_IN = 1'b0;
        tick();
        RESETn = 1'b1;
        tick();
        chk("mid_idle", BUSY, 0);
        WORD_READY = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("3c_out", WORD_OUT, 32'h3C);
        chk("3c_valid", WORD_VALID, 1);
        chk("3c_count", FRAME_COUNT, 1);
        chk("3c_errs", {PARITY_ERR, FRAME_ERR, OVERRUN_ERR}, 0);

        // Counter wrap: 255 more good frames back-to-back
        for (int i = 0; i < 254; i++) begin
            logic [7:0] d;
            d = 8'(i);
            send_frame(d, ^d, 1'b0, 1'b1);
        end
        chk("wrap_pre", FRAME_COUNT, 255);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        chk("wrap_count", FRAME_COUNT, 0);
        chk("wrap_out", WORD_OUT, 32'h5A);
        chk("wrap_valid", WORD_VALID, 1);
        chk("wrap_errs", {PARITY_ERR, FRAME_ERR, OVERRUN_ERR}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
